// File: rtl/xmem_req_arbiter_if.sv
// Xmem requester-side and core-side signal bundle for xmem_req_arbiter.
// master = arbiter view, slave = environment (requesters + core) view.
package xmem_req_arbiter_pkg;
  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_req_type_e;
endpackage

interface xmem_req_arbiter_if #(parameter int NumReq = 2);
  import xmem_req_arbiter_pkg::*;

  logic [NumReq-1:0]        req_valid_i, req_ready_o;
  logic [NumReq-1:0][31:0]  req_laddr_i, req_wdata_i;
  logic [NumReq-1:0][2:0]   req_width_i;
  mem_req_type_e [NumReq-1:0] req_type_i;
  logic [NumReq-1:0]        req_mode_i, req_spec_i, req_eot_i;
  logic [NumReq-1:0]        rsp_valid_o, rsp_ready_i;
  logic [31:0]              rsp_rdata_o;
  logic [4:0]               rsp_range_o;
  logic                     rsp_status_o;
  logic                     xmem_q_valid_o, xmem_q_ready_i;
  logic [31:0]              xmem_q_laddr_o, xmem_q_wdata_o;
  logic [2:0]               xmem_q_width_o;
  mem_req_type_e            xmem_q_req_type_o;
  logic                     xmem_q_mode_o, xmem_q_spec_o, xmem_q_endoftransaction_o;
  logic                     xmem_p_valid_i, xmem_p_ready_o;
  logic [31:0]              xmem_p_rdata_i;
  logic [4:0]               xmem_p_range_i;
  logic                     xmem_p_status_i;
  logic                     err_o;
  logic [31:0]              stall_cnt_o;

  modport master (
    input  req_valid_i, req_laddr_i, req_wdata_i, req_width_i, req_type_i,
           req_mode_i, req_spec_i, req_eot_i, rsp_ready_i, xmem_q_ready_i,
           xmem_p_valid_i, xmem_p_rdata_i, xmem_p_range_i, xmem_p_status_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_range_o, rsp_status_o,
           xmem_q_valid_o, xmem_q_laddr_o, xmem_q_wdata_o, xmem_q_width_o,
           xmem_q_req_type_o, xmem_q_mode_o, xmem_q_spec_o,
           xmem_q_endoftransaction_o, xmem_p_ready_o, err_o, stall_cnt_o
  );

  modport slave (
    output req_valid_i, req_laddr_i, req_wdata_i, req_width_i, req_type_i,
           req_mode_i, req_spec_i, req_eot_i, rsp_ready_i, xmem_q_ready_i,
           xmem_p_valid_i, xmem_p_rdata_i, xmem_p_range_i, xmem_p_status_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_range_o, rsp_status_o,
           xmem_q_valid_o, xmem_q_laddr_o, xmem_q_wdata_o, xmem_q_width_o,
           xmem_q_req_type_o, xmem_q_mode_o, xmem_q_spec_o,
           xmem_q_endoftransaction_o, xmem_p_ready_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/xmem_req_arbiter.sv
// Round-robin Xmem request arbiter with transaction lock and in-order response routing.
// Optional stall counter enabled by `define XMEM_REQ_ARB_PERF_EN.
module xmem_req_arbiter
  import xmem_req_arbiter_pkg::*;
#(
  parameter int NumReq         = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  xmem_req_arbiter_if.master bus
);
  localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int AW = $clog2(MaxOutstanding);
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, LOCKED = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr, lock_idx, arb_g, grant, next_g, head;
  logic          arb_found;
  logic [IW-1:0] fifo_mem [MaxOutstanding];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, q_valid, hs, pop, p_ready;
  logic [NumReq-1:0] req_ready, rsp_valid;
  logic [IW:0]   idx;

  // First valid requester at or after rr_ptr, wrapping at NumReq.
  always_comb begin
    arb_g     = rr_ptr;
    arb_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NumReq)) idx = idx - (IW+1)'(NumReq);
      if (!arb_found && bus.req_valid_i[idx[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_g     = idx[IW-1:0];
      end
    end
  end

  assign grant   = (state == IDLE) ? arb_g : lock_idx;
  assign next_g  = (grant == IW'(NumReq - 1)) ? '0 : grant + 1'b1;
  assign full    = (count == (AW+1)'(MaxOutstanding));
  assign empty   = (count == '0);
  assign q_valid = bus.req_valid_i[grant] & ~full;
  assign hs      = q_valid & bus.xmem_q_ready_i;

  always_comb begin
    req_ready = '0;
    if (state != IDLE || arb_found) req_ready[grant] = bus.xmem_q_ready_i & ~full;
  end

  assign bus.req_ready_o               = req_ready;
  assign bus.xmem_q_valid_o            = q_valid;
  assign bus.xmem_q_laddr_o            = bus.req_laddr_i[grant];
  assign bus.xmem_q_wdata_o            = bus.req_wdata_i[grant];
  assign bus.xmem_q_width_o            = bus.req_width_i[grant];
  assign bus.xmem_q_req_type_o         = bus.req_type_i[grant];
  assign bus.xmem_q_mode_o             = bus.req_mode_i[grant];
  assign bus.xmem_q_spec_o             = bus.req_spec_i[grant];
  assign bus.xmem_q_endoftransaction_o = bus.req_eot_i[grant];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs && bus.req_eot_i[grant]) rr_ptr <= next_g;
          else if (q_valid) begin
            // Presented but not yet finished: pin the grant until eot is accepted.
            state    <= hs ? LOCKED : HOLD;
            lock_idx <= grant;
          end
        end
        HOLD, LOCKED: begin
          if (hs && bus.req_eot_i[grant]) begin
            state  <= IDLE;
            rr_ptr <= next_g;
          end else if (hs) state <= LOCKED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response side: head of the ID FIFO owns the response channel.
  assign head    = fifo_mem[rd_ptr];
  assign p_ready = bus.rsp_ready_i[head] & ~empty;
  assign pop     = bus.xmem_p_valid_i & p_ready;

  always_comb begin
    rsp_valid = '0;
    if (!empty) rsp_valid[head] = bus.xmem_p_valid_i;
  end

  assign bus.rsp_valid_o    = rsp_valid;
  assign bus.xmem_p_ready_o = p_ready;
  assign bus.rsp_rdata_o    = bus.xmem_p_rdata_i;
  assign bus.rsp_range_o    = bus.xmem_p_range_i;
  assign bus.rsp_status_o   = bus.xmem_p_status_i;

  always_ff @(posedge clk_i) begin
    if (hs) fifo_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      bus.err_o <= 1'b0;
    end else begin
      if (hs)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (bus.xmem_p_valid_i && empty) bus.err_o <= 1'b1;
    end
  end

`ifdef XMEM_REQ_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bus.stall_cnt_o <= '0;
    else if (|bus.req_valid_i && !hs && bus.stall_cnt_o != 32'hFFFF_FFFF)
      bus.stall_cnt_o <= bus.stall_cnt_o + 1'b1;
  end
`else
  assign bus.stall_cnt_o = '0;
`endif
endmodule
